work_ctrl_n: RTL
================

Name: work_ctrl_n

Overview:
- Parametrised N-channel successor to the two-channel UART work controller in sig_acq.
- On a start command, it programs baud and self-loop on every UART channel. It then moves bytes from each channel's RX FIFO to a TX FIFO, selected per channel by a route mode, using round-robin scheduling.
- It keeps a saturating RX-overflow counter per channel.
- Sits between the host/config register file and the NCH uart channel instances.

Parameters:
- NCH, 2, number of UART channels (2..8)
- DW, 8, FIFO data width
- AW, 5, FIFO usedw width
- BW, 16, baud word width
- BAUD_DEF, 16'd434, baud word driven out of reset
- CW, 16, overflow counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle pulse: configure channels and begin forwarding
- cfg_stop  in  1  one-cycle pulse: finish the in-flight byte, then go idle
- cfg_baud  in  BW  baud word applied to all channels
- cfg_loop  in  NCH  per-channel self-loop enable
- cfg_route  in  NCH  per channel: 0 = echo to own TX, 1 = forward to channel (i+1) mod NCH
- cnt_clr  in  1  clear all overflow counters
- latch_baud  out  NCH  baud latch strobes
- baud_word  out  NCH*BW  baud words; channel i occupies bits [i*BW +: BW]
- self_loop  out  NCH  self-loop controls
- tx_fifo_wen  out  NCH  TX FIFO write enables
- tx_fifo_wdata  out  NCH*DW  TX write data
- tx_fifo_empty, tx_fifo_full  in  NCH  TX FIFO flags
- tx_fifo_usedw  in  NCH*AW  TX FIFO fill levels (status only)
- rx_fifo_ren  out  NCH  RX FIFO read enables
- rx_fifo_rdata  in  NCH*DW  RX read data
- rx_fifo_empty, rx_fifo_full  in  NCH  RX FIFO flags
- rx_fifo_usedw  in  NCH*AW  RX FIFO fill levels (status only)
- tx_work, rx_overflow  in  NCH  per-channel activity / overflow flags
- busy  out  1  high in any state other than IDLE
- ovf_cnt  out  NCH*CW  per-channel overflow counts
- fwd_cnt  out  32  total bytes forwarded, wraps

Behaviour:
- Reset values: all strobes/enables 0, wdata 0, baud_word = BAUD_DEF on every channel, self_loop 0, busy 0, counters 0, rr pointer 0, state IDLE.
- FSM states: IDLE, CFG, SCAN, RD, LAT, WR.
- IDLE: on cfg_start go to CFG.
- CFG (1 cycle):
  - registers cfg_baud into every baud_word and cfg_loop into self_loop;
  - latch_baud = all ones for exactly this cycle;
  - registers cfg_route;
  - goes to SCAN.
- SCAN:
  - eligible(i) = !rx_fifo_empty[i] && !tx_fifo_full[dst(i)], where dst(i) uses the registered route.
  - Round-robin search starts at ptr. The first eligible channel becomes sel and the FSM goes to RD.
  - If none is eligible, stay in SCAN.
  - If a stop is pending, go to IDLE.
- RD: rx_fifo_ren[sel] = 1 for one cycle; go to LAT.
- LAT: RX FIFO has 1-cycle read latency; capture rx_fifo_rdata[sel] at the end of LAT; go to WR.
- WR:
  - tx_fifo_wen[dst(sel)] = 1 for one cycle with the captured byte;
  - fwd_cnt increments;
  - ptr = (sel+1) mod NCH;
  - go to SCAN, or to IDLE if a stop is pending.
- Timing: ren at cycle T, wen at T+2. Peak throughput is one byte per 4 cycles.
- Only this block writes the TX FIFOs, so the full check made in SCAN remains valid at WR.
- cfg_stop: sets stop_pend. It does not abort RD/LAT/WR. stop_pend is cleared on entry to IDLE.
- cfg_start outside IDLE is ignored. cfg_start and cfg_stop in the same cycle in IDLE: start wins and stop is ignored.
- cfg_route/cfg_loop changes take effect only at the next CFG.
- Two channels routing into the same TX FIFO is legal; the round-robin pointer ensures fairness.
- ovf_cnt[i]:
  - increments on a 0->1 edge of rx_overflow[i] (1-cycle registered edge detect);
  - saturates at all ones;
  - cnt_clr has priority over a same-cycle edge, leaving the counter at 0;
  - counts in every state, including IDLE.
- tx_work, usedw and rx_fifo_full: no control effect; these are routed to status only.
- Reset mid-transfer: the in-flight byte is dropped and all outputs return to their reset values on the next edge.

Decomposition:
- Package sig_acq_pkg: state encoding localparams, BAUD_DEF, and a dst(i, route) helper function.
- Sub-module rr_arbiter #(NCH): inputs req[NCH] and ptr, outputs gnt_idx and gnt_vld. Purely combinational; ptr is stored in the parent.

Test Plan:
- Reset, then cfg_start with cfg_baud=16'h01B2 and cfg_loop=2'b01 → latch_baud=2'b11 for exactly one cycle; baud_word = {16'h01B2,16'h01B2}; self_loop = 2'b01; busy=1.
- Echo with NCH=2, route=00: load RX0 with 0xA5 → ren0 at T, wen0 at T+2 with wdata 0xA5; fwd_cnt=1.
- Forward with route=11: RX0 holds 0x11,0x22 and RX1 holds 0x33 → TX1 receives 0x11 then 0x22; TX0 receives 0x33 between them (order 0x11, 0x33, 0x22, per alternating round-robin).
- tx_fifo_full[1]=1 with route=11 and RX0 non-empty → no ren0. Releasing full → transfer proceeds within 1 cycle of SCAN.
- cfg_stop during LAT → the WR still occurs, then IDLE with busy=0. A later cfg_start re-runs CFG.
- Three rx_overflow[0] pulses, then cnt_clr coincident with a fourth edge → ovf_cnt[0] reads 3, then 0. Force CW=2 and 5 edges → saturates at 3.

Source files
------------

// File: rtl/work_ctrl_n_pkg.sv
// Shared types and helpers for the N-channel UART work controller.
package work_ctrl_n_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_SCAN = 3'd2,
    ST_RD   = 3'd3,
    ST_LAT  = 3'd4,
    ST_WR   = 3'd5
  } state_e;

  localparam logic [15:0] BAUD_DEF_P = 16'd434;

  // Destination TX channel for source channel i: own TX, or the next channel around the ring.
  function automatic int unsigned dst(input int unsigned i, input logic route, input int unsigned nch);
    if (route) return (i + 1) % nch;
    else       return i;
  endfunction

endpackage

// File: rtl/work_ctrl_n_if.sv
// Bundle of the per-channel UART/FIFO signals between the controller and the channel instances.
interface work_ctrl_n_if #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int AW  = 5,
  parameter int BW  = 16
);
  logic [NCH-1:0]    latch_baud;
  logic [NCH*BW-1:0] baud_word;
  logic [NCH-1:0]    self_loop;
  logic [NCH-1:0]    tx_fifo_wen;
  logic [NCH*DW-1:0] tx_fifo_wdata;
  logic [NCH-1:0]    tx_fifo_empty;
  logic [NCH-1:0]    tx_fifo_full;
  logic [NCH*AW-1:0] tx_fifo_usedw;
  logic [NCH-1:0]    rx_fifo_ren;
  logic [NCH*DW-1:0] rx_fifo_rdata;
  logic [NCH-1:0]    rx_fifo_empty;
  logic [NCH-1:0]    rx_fifo_full;
  logic [NCH*AW-1:0] rx_fifo_usedw;
  logic [NCH-1:0]    tx_work;
  logic [NCH-1:0]    rx_overflow;

  modport master (
    output latch_baud, baud_word, self_loop, tx_fifo_wen, tx_fifo_wdata, rx_fifo_ren,
    input  tx_fifo_empty, tx_fifo_full, tx_fifo_usedw, rx_fifo_rdata, rx_fifo_empty,
           rx_fifo_full, rx_fifo_usedw, tx_work, rx_overflow
  );

  modport slave (
    input  latch_baud, baud_word, self_loop, tx_fifo_wen, tx_fifo_wdata, rx_fifo_ren,
    output tx_fifo_empty, tx_fifo_full, tx_fifo_usedw, rx_fifo_rdata, rx_fifo_empty,
           rx_fifo_full, rx_fifo_usedw, tx_work, rx_overflow
  );
endinterface

// File: rtl/work_ctrl_n_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [PW-1:0]  gnt_idx,
  output logic           gnt_vld
);

  logic [PW-1:0] idx;

  // Walk from the farthest offset down so the nearest requester to ptr wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    idx     = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = PW'((32'(ptr) + 32'(k)) % 32'(NCH));
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/work_ctrl_n.sv
// N-channel UART work controller: programs baud/self-loop, then forwards RX bytes to routed TX FIFOs.
module work_ctrl_n
  import work_ctrl_n_pkg::*;
#(
  parameter int            NCH      = 2,
  parameter int            DW       = 8,
  parameter int            AW       = 5,
  parameter int            BW       = 16,
  parameter logic [BW-1:0] BAUD_DEF = BW'(BAUD_DEF_P),
  parameter int            CW       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [BW-1:0]     cfg_baud,
  input  logic [NCH-1:0]    cfg_loop,
  input  logic [NCH-1:0]    cfg_route,
  input  logic              cnt_clr,
  work_ctrl_n_if.master     ch,
  output logic              busy,
  output logic [NCH*CW-1:0] ovf_cnt,
  output logic [31:0]       fwd_cnt
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e         state_q, state_d;
  logic           stop_pend_q;
  logic [NCH-1:0] route_q, self_loop_q;
  logic [BW-1:0]  baud_q;
  logic [PW-1:0]  ptr_q, sel_q, dst_sel, gnt_idx;
  logic           gnt_vld;
  logic [NCH-1:0] req;
  logic [DW-1:0]  data_q;
  logic [31:0]    fwd_cnt_q;
  logic [NCH-1:0] ovf_prev_q;
  logic [CW-1:0]  ovf_cnt_q [NCH];

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign dst_sel       = PW'(dst(32'(sel_q), route_q[sel_q], NCH));
  assign busy          = (state_q != ST_IDLE);
  assign fwd_cnt       = fwd_cnt_q;
  assign ch.latch_baud = {NCH{state_q == ST_CFG}};
  assign ch.self_loop  = self_loop_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam int unsigned NXT = dst(gi, 1'b1, NCH);

    assign req[gi] = !ch.rx_fifo_empty[gi] &&
                     (route_q[gi] ? !ch.tx_fifo_full[NXT] : !ch.tx_fifo_full[gi]);
    assign ch.baud_word[gi*BW +: BW]     = baud_q;
    assign ch.tx_fifo_wdata[gi*DW +: DW] = data_q;
    assign ch.rx_fifo_ren[gi] = (state_q == ST_RD) && (sel_q == PW'(gi));
    assign ch.tx_fifo_wen[gi] = (state_q == ST_WR) && (dst_sel == PW'(gi));
    assign ovf_cnt[gi*CW +: CW] = ovf_cnt_q[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        ovf_prev_q[gi] <= 1'b0;
        ovf_cnt_q[gi]  <= '0;
      end else begin
        ovf_prev_q[gi] <= ch.rx_overflow[gi];
        if (cnt_clr)
          ovf_cnt_q[gi] <= '0;
        else if (ch.rx_overflow[gi] && !ovf_prev_q[gi] && (ovf_cnt_q[gi] != '1))
          ovf_cnt_q[gi] <= ovf_cnt_q[gi] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cfg_start) state_d = ST_CFG;
      ST_CFG:  state_d = ST_SCAN;
      ST_SCAN: begin
        if (stop_pend_q)  state_d = ST_IDLE;
        else if (gnt_vld) state_d = ST_RD;
      end
      ST_RD:   state_d = ST_LAT;
      ST_LAT:  state_d = ST_WR;
      ST_WR:   state_d = stop_pend_q ? ST_IDLE : ST_SCAN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Config words are captured with the start pulse so they are already stable while latch_baud strobes in CFG.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      route_q     <= '0;
      self_loop_q <= '0;
      baud_q      <= BAUD_DEF;
      ptr_q       <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_IDLE)
        stop_pend_q <= 1'b0;
      else if (cfg_stop && state_q != ST_IDLE)
        stop_pend_q <= 1'b1;
      if (state_q == ST_IDLE && cfg_start) begin
        baud_q      <= cfg_baud;
        self_loop_q <= cfg_loop;
        route_q     <= cfg_route;
      end
      if (state_q == ST_SCAN && state_d == ST_RD)
        sel_q <= gnt_idx;
      if (state_q == ST_LAT)
        data_q <= ch.rx_fifo_rdata[sel_q*DW +: DW];
      if (state_q == ST_WR) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
        ptr_q     <= PW'(dst(32'(sel_q), 1'b1, NCH));
      end
    end
  end

endmodule
